// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - clocked ALU with iterative multiply/divide and valid/ready handshake
//
// Purpose: single-cycle ALU op set plus radix-2 iterative MUL/MULT/MULTU/DIV/DIVU.
// One operation is in flight at a time. Single-cycle ops show OutValid one cycle
// after the accept edge. Multi-cycle ops show it WIDTH+1 cycles after the accept edge.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   InValid    in   operands/op valid
//   InReady    out  block can accept (high only in IDLE)
//   ALUControl in   6-bit operation select
//   A, B       in   operands; A[SHW-1:0] is the shift amount for shifts
//   OutValid   out  result valid
//   OutReady   in   consumer takes result
//   ALUResult  out  primary result (Lo / quotient for mult/div)
//   Hi         out  upper product / remainder; 0 for single-cycle ops
//   Zero       out  ALUResult == 0
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [5:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LP_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_hi;        // partial product upper half / partial remainder
  logic [WIDTH-1:0] r_lo;        // multiplier being consumed / dividend-quotient
  logic [WIDTH-1:0] r_opnd;      // multiplicand / divisor magnitude
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div;
  logic             r_lo_only;   // MUL: only low half reported, Hi forced to 0
  logic             r_neg_q;     // product or quotient must be negated
  logic             r_neg_r;     // remainder must be negated
  logic             r_bzero;
  logic [WIDTH-1:0] r_a;         // original dividend, returned as remainder on divide by zero
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi_out;
  logic             r_out_valid;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;

  assign w_is_mul = (ALUControl == 6'd3) || (ALUControl == 6'd21) || (ALUControl == 6'd22);
  assign w_is_div = (ALUControl == 6'd23) || (ALUControl == 6'd24);
  assign w_signed = (ALUControl == 6'd3) || (ALUControl == 6'd21) || (ALUControl == 6'd23);
  assign w_a_neg  = w_signed & A[WIDTH-1];
  assign w_b_neg  = w_signed & B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  assign w_sh     = A[SHW-1:0];

  always_comb begin
    w_alu = '1;
    case (ALUControl)
      6'd0:                w_alu = A & B;
      6'd1:                w_alu = A | B;
      6'd2, 6'd19:         w_alu = A + B;
      6'd6:                w_alu = A - B;
      6'd7:                w_alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      6'd20:               w_alu = {{(WIDTH-1){1'b0}}, A < B};
      6'd8, 6'd16:         w_alu = B << w_sh;
      6'd9, 6'd17:         w_alu = B >> w_sh;
      6'd11, 6'd18:        w_alu = $signed(B) >>> w_sh;
      6'd13:               w_alu = A ^ B;
      6'd14:               w_alu = ~(A | B);
      6'd38:               w_alu = B << 16;
      default:             w_alu = '1;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half when the low bit is set,
  // then shift the whole Hi:Lo pair right, keeping the carry.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_hi_nx;
  logic [WIDTH-1:0] w_mul_lo_nx;
  assign w_sum       = r_hi + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_hi_nx = {1'b0, w_sum[WIDTH:1]};
  assign w_mul_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder, trial subtract;
  // a borrow (bit WIDTH set) means keep the shifted remainder and record a 0.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_div_hi_nx;
  logic [WIDTH-1:0] w_div_lo_nx;
  assign w_shift     = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_opnd};
  assign w_div_hi_nx = w_diff[WIDTH] ? w_shift : w_diff;
  assign w_div_lo_nx = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};

  logic [WIDTH:0]     w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;
  assign w_hi_nx = r_is_div ? w_div_hi_nx : w_mul_hi_nx;
  assign w_lo_nx = r_is_div ? w_div_lo_nx : w_mul_lo_nx;

  // Sign correction is applied to the values produced by the final iteration so the
  // result registers load on the same edge as the last step.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fin_lo;
  logic [WIDTH-1:0]   w_fin_hi;
  assign w_prod   = {w_hi_nx[WIDTH-1:0], w_lo_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nx : w_lo_nx;
  assign w_rem    = r_neg_r ? -w_hi_nx[WIDTH-1:0] : w_hi_nx[WIDTH-1:0];

  always_comb begin
    w_fin_lo = w_prod_s[WIDTH-1:0];
    w_fin_hi = w_prod_s[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      w_fin_lo = r_bzero ? {WIDTH{1'b1}} : w_quo;
      w_fin_hi = r_bzero ? r_a : w_rem;
    end else if (r_lo_only) begin
      w_fin_hi = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_lo_only   <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_bzero     <= 1'b0;
      r_a         <= '0;
      r_result    <= '0;
      r_hi_out    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            if (w_is_mul || w_is_div) begin
              r_is_div  <= w_is_div;
              r_lo_only <= (ALUControl == 6'd3);
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_bzero   <= (B == '0);
              r_a       <= A;
              r_cnt     <= '0;
              r_hi      <= '0;
              r_lo      <= w_is_div ? w_a_mag : w_b_mag;
              r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
              r_state   <= S_BUSY;
            end else begin
              r_result    <= w_alu;
              r_hi_out    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_result    <= w_fin_lo;
            r_hi_out    <= w_fin_hi;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign InReady   = (r_state == S_IDLE);
  assign OutValid  = r_out_valid;
  assign ALUResult = r_result;
  assign Hi        = r_hi_out;
  assign Zero      = (r_result == '0);

endmodule
